// File: rtl/imm_disp_extract_pipe_if.sv
// Valid/ready bundle between the decode byte aligner, the imm/disp extractor and the AG latch.
// The master side drives words in and accepts results; the slave side is the extractor.
interface imm_disp_extract_pipe_if #(
   parameter int FIELD_BYTES    = 8,
   parameter int IMM_MAX_BYTES  = 6,
   parameter int DISP_MAX_BYTES = 4
);
   logic                        flush;
   logic                        in_valid;
   logic                        in_ready;
   logic [FIELD_BYTES*8-1:0]    in_field;
   logic [3:0]                  in_imm_bytes;
   logic [3:0]                  in_disp_bytes;
   logic [1:0]                  in_op_size;
   logic                        out_valid;
   logic                        out_ready;
   logic [IMM_MAX_BYTES*8-1:0]  out_imm;
   logic [DISP_MAX_BYTES*8-1:0] out_disp;
   logic                        out_err;
   logic [7:0]                  err_count;

   modport master (
      output flush, in_valid, in_field, in_imm_bytes, in_disp_bytes, in_op_size, out_ready,
      input  in_ready, out_valid, out_imm, out_disp, out_err, err_count
   );

   modport slave (
      input  flush, in_valid, in_field, in_imm_bytes, in_disp_bytes, in_op_size, out_ready,
      output in_ready, out_valid, out_imm, out_disp, out_err, err_count
   );
endinterface

// File: rtl/imm_disp_extract_pipe.sv
// Two-stage imm/disp extractor: S1 registers the packed field, the extracted result is written
// into a DEPTH-entry FIFO that feeds the decode-to-AG latch through a valid/ready handshake.
module imm_disp_extract_pipe #(
   parameter int FIELD_BYTES    = 8,
   parameter int IMM_MAX_BYTES  = 6,
   parameter int DISP_MAX_BYTES = 4,
   parameter int DEPTH          = 2
) (
   input logic clk,
   input logic reset,
   imm_disp_extract_pipe_if.slave bus
);
   localparam int FW = FIELD_BYTES * 8;
   localparam int IW = IMM_MAX_BYTES * 8;
   localparam int DW = DISP_MAX_BYTES * 8;
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 2);

   typedef struct packed {
      logic [IW-1:0] imm;
      logic [DW-1:0] disp;
      logic          err;
   } result_t;

   logic          s1_valid;
   logic [FW-1:0] s1_field;
   logic [3:0]    s1_imm_bytes;
   logic [3:0]    s1_disp_bytes;
   logic [1:0]    s1_op_size;
   logic [7:0]    stream [FIELD_BYTES];
   result_t       s1_result;
   result_t       mem [DEPTH];
   result_t       head;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [CW-1:0] occupancy;
   logic          imm_legal;
   logic          disp_legal;
   logic [4:0]    span;
   logic          accept;
   logic          push;
   logic          pop;

   function automatic logic [PW-1:0] bump(input logic [PW-1:0] ptr);
      return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
   endfunction

   // Admission counts S1 plus the FIFO, so a word in S1 always finds a free FIFO slot next cycle.
   assign pop          = bus.out_valid & bus.out_ready;
   assign occupancy    = CW'(s1_valid) + count - CW'(pop);
   assign bus.in_ready = !reset && !bus.flush && (occupancy < CW'(DEPTH));
   assign accept       = bus.in_valid & bus.in_ready;
   assign push         = s1_valid;

   always_comb begin
      for (int k = 0; k < FIELD_BYTES; k++) begin
         stream[k] = s1_field[FW-1-8*k -: 8];
      end
   end

   always_comb begin
      s1_result  = '0;
      imm_legal  = s1_imm_bytes inside {4'd0, 4'd1, 4'd2, 4'd4, 4'(IMM_MAX_BYTES)};
      disp_legal = s1_disp_bytes inside {4'd0, 4'd1, 4'(DISP_MAX_BYTES)};
      span       = {1'b0, s1_imm_bytes} + {1'b0, s1_disp_bytes};
      if (!imm_legal || !disp_legal || (span > 5'(FIELD_BYTES))) begin
         s1_result.err = 1'b1;
      end else begin
         for (int j = 0; j < DISP_MAX_BYTES; j++) begin
            if (4'(j) < s1_disp_bytes) begin
               s1_result.disp[8*j +: 8] = stream[j];
            end
         end
         if ((s1_disp_bytes == 4'd1) && stream[0][7]) begin
            s1_result.disp[DW-1:8] = '1;
         end
         // Immediate bytes follow the displacement, so stream byte k maps to imm byte k-D.
         for (int k = 0; k < FIELD_BYTES; k++) begin
            for (int j = 0; j < IMM_MAX_BYTES; j++) begin
               if ((4'(j) < s1_imm_bytes) && (5'(k) == ({1'b0, s1_disp_bytes} + 5'(j)))) begin
                  s1_result.imm[8*j +: 8] = stream[k];
               end
            end
         end
         if ((s1_imm_bytes == 4'd1) && s1_result.imm[7]) begin
            if (s1_op_size == 2'd1) begin
               s1_result.imm[15:8] = '1;
            end else if (s1_op_size[1]) begin
               s1_result.imm[31:8] = '1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset || bus.flush) begin
         s1_valid      <= 1'b0;
         s1_field      <= '0;
         s1_imm_bytes  <= '0;
         s1_disp_bytes <= '0;
         s1_op_size    <= '0;
      end else begin
         s1_valid <= accept;
         if (accept) begin
            s1_field      <= bus.in_field;
            s1_imm_bytes  <= bus.in_imm_bytes;
            s1_disp_bytes <= bus.in_disp_bytes;
            s1_op_size    <= bus.in_op_size;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset || bus.flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= bump(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= bump(rd_ptr);
         end
         count <= count + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= s1_result;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bus.err_count <= '0;
      end else if (pop && bus.out_err && (bus.err_count != 8'hFF)) begin
         bus.err_count <= bus.err_count + 8'd1;
      end
   end

   always_comb begin
      head          = mem[rd_ptr];
      bus.out_valid = (count != '0);
      bus.out_imm   = bus.out_valid ? head.imm  : '0;
      bus.out_disp  = bus.out_valid ? head.disp : '0;
      bus.out_err   = bus.out_valid ? head.err  : 1'b0;
   end
endmodule

// File: tb/tb_imm_disp_extract_pipe.sv
// Bench for imm_disp_extract_pipe: directed vectors with literal results, then random traffic
// checked every cycle against a queue-based model of accepted words and their due cycles.
module tb_imm_disp_extract_pipe;
   localparam int DEPTH = 2;

   logic clk;
   logic reset;

   imm_disp_extract_pipe_if bus ();

   imm_disp_extract_pipe #(
      .FIELD_BYTES   (8),
      .IMM_MAX_BYTES (6),
      .DISP_MAX_BYTES(4),
      .DEPTH         (DEPTH)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [47:0] imm;
      logic [31:0] disp;
      logic        err;
   } res_t;

   typedef struct {
      logic [47:0] imm;
      logic [31:0] disp;
      logic        err;
      int          due;
   } exp_t;

   int assertCount;
   int failCount;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      assertCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, wanted %0h", name, act, exp);
      end
   endtask

   task automatic timeoutFail(input string name);
      assertCount++;
      failCount++;
      $display("[TB] FAIL %s: timed out waiting for the DUT", name);
   endtask

   // Reference extraction straight from the byte-count rules.
   function automatic res_t refExtract(input logic [63:0] field, input int ib, input int db, input int op);
      res_t        r;
      logic [7:0]  b [8];
      logic [63:0] v;
      r.imm  = '0;
      r.disp = '0;
      r.err  = 1'b0;
      for (int k = 0; k < 8; k++) b[k] = field[63-8*k -: 8];
      if (!(ib inside {0, 1, 2, 4, 6}) || !(db inside {0, 1, 4}) || (ib + db > 8)) begin
         r.err = 1'b1;
         return r;
      end
      v = '0;
      for (int j = 0; j < db; j++) v = v | (64'(b[j]) << (8 * j));
      r.disp = v[31:0];
      if (db == 1 && b[0][7]) r.disp = r.disp | 32'hFFFF_FF00;
      v = '0;
      for (int j = 0; j < ib; j++) v = v | (64'(b[db+j]) << (8 * j));
      r.imm = v[47:0];
      if (ib == 1 && b[db][7]) begin
         if (op == 1) r.imm = r.imm | 48'h0000_0000_FF00;
         else if (op >= 2) r.imm = r.imm | 48'h0000_FFFF_FF00;
      end
      return r;
   endfunction

   // Per-cycle model: every accepted word becomes visible two cycles later, in order.
   exp_t       q[$];
   int         cyc;
   logic [7:0] errExp;

   initial begin
      bit   expValid;
      bit   popNow;
      bit   expReady;
      res_t r;
      exp_t e;
      cyc    = 0;
      errExp = 8'd0;
      forever begin
         @(negedge clk);
         cyc++;
         if (reset) begin
            checkOutput("in_ready_in_reset", 64'(bus.in_ready), 64'd0);
            q.delete();
            errExp = 8'd0;
         end else begin
            expValid = (q.size() > 0) && (q[0].due <= cyc);
            checkOutput("out_valid", 64'(bus.out_valid), 64'(expValid));
            if (expValid) begin
               checkOutput("out_imm", 64'(bus.out_imm), 64'(q[0].imm));
               checkOutput("out_disp", 64'(bus.out_disp), 64'(q[0].disp));
               checkOutput("out_err", 64'(bus.out_err), 64'(q[0].err));
            end
            popNow   = expValid && bus.out_ready;
            expReady = !bus.flush && ((q.size() - int'(popNow)) < DEPTH);
            checkOutput("in_ready", 64'(bus.in_ready), 64'(expReady));
            checkOutput("err_count", 64'(bus.err_count), 64'(errExp));
            if (popNow) begin
               if (q[0].err && errExp != 8'hFF) errExp = errExp + 8'd1;
               void'(q.pop_front());
            end
            if (bus.flush) begin
               q.delete();
            end else if (bus.in_valid && expReady) begin
               r      = refExtract(bus.in_field, int'(bus.in_imm_bytes), int'(bus.in_disp_bytes),
                                   int'(bus.in_op_size));
               e.imm  = r.imm;
               e.disp = r.disp;
               e.err  = r.err;
               e.due  = cyc + 2;
               q.push_back(e);
            end
         end
      end
   end

   task automatic applyStimulus(input logic [63:0] field, input int ib, input int db, input int op);
      @(posedge clk);
      #1;
      bus.in_field      = field;
      bus.in_imm_bytes  = 4'(ib);
      bus.in_disp_bytes = 4'(db);
      bus.in_op_size    = 2'(op);
      bus.in_valid      = 1'b1;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            return;
         end
      end
      bus.in_valid = 1'b0;
      timeoutFail("accept");
   endtask

   task automatic checkResult(input string name, input logic [47:0] imm, input logic [31:0] disp,
                              input logic err);
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (bus.out_valid) begin
            checkOutput({name, "_imm"}, 64'(bus.out_imm), 64'(imm));
            checkOutput({name, "_disp"}, 64'(bus.out_disp), 64'(disp));
            checkOutput({name, "_err"}, 64'(bus.out_err), 64'(err));
            return;
         end
      end
      timeoutFail(name);
   endtask

   function automatic logic [63:0] streamWord(input int k);
      return 64'h1020_3040_5060_7080 + 64'(k * 64'h0101_0101_0101_0101);
   endfunction

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      res_t r;
      int   accepted;
      int   delivered;
      int   ib;
      int   db;
      int   immTable [5];
      int   dispTable [3];
      immTable  = '{0, 1, 2, 4, 6};
      dispTable = '{0, 1, 4};
      assertCount = 0;
      failCount   = 0;

      reset             = 1'b1;
      bus.flush         = 1'b0;
      bus.in_valid      = 1'b0;
      bus.in_field      = '0;
      bus.in_imm_bytes  = '0;
      bus.in_disp_bytes = '0;
      bus.in_op_size    = '0;
      bus.out_ready     = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      @(negedge clk);
      checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
      checkOutput("rst_out_imm", 64'(bus.out_imm), 64'd0);
      checkOutput("rst_out_disp", 64'(bus.out_disp), 64'd0);
      checkOutput("rst_out_err", 64'(bus.out_err), 64'd0);
      checkOutput("rst_err_count", 64'(bus.err_count), 64'd0);
      checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd1);

      r = refExtract(64'hF001_0203_0400_0000, 4, 1, 2);
      checkOutput("model_disp_sext", 64'(r.disp), 64'hFFFF_FFF0);
      checkOutput("model_imm_zext", 64'(r.imm), 64'h0000_0403_0201);
      r = refExtract(64'h8000_0000_0000_0000, 1, 0, 1);
      checkOutput("model_imm_sext16", 64'(r.imm), 64'h0000_0000_FF80);
      r = refExtract(64'h8000_0000_0000_0000, 1, 0, 0);
      checkOutput("model_imm_raw8", 64'(r.imm), 64'h0000_0000_0080);
      r = refExtract(64'h0, 6, 4, 2);
      checkOutput("model_err_span", 64'(r.err), 64'd1);

      // Displacement bytes lead the stream, immediate byte follows at stream byte 4.
      applyStimulus(64'h2233_4455_1166_0000, 1, 4, 2);
      checkResult("t1_d4_i1", 48'h0000_0000_0011, 32'h5544_3322, 1'b0);
      applyStimulus(64'hF001_0203_0400_0000, 4, 1, 2);
      checkResult("t2_d1_i4", 48'h0000_0403_0201, 32'hFFFF_FFF0, 1'b0);
      applyStimulus(64'h8000_0000_0000_0000, 1, 0, 1);
      checkResult("t3_op16", 48'h0000_0000_FF80, 32'h0, 1'b0);
      applyStimulus(64'h8000_0000_0000_0000, 1, 0, 0);
      checkResult("t3_op8", 48'h0000_0000_0080, 32'h0, 1'b0);
      applyStimulus(64'h8000_0000_0000_0000, 1, 0, 3);
      checkResult("t3_op48", 48'h0000_FFFF_FF80, 32'h0, 1'b0);

      applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 6, 4, 2);
      checkResult("t4_err", 48'h0, 32'h0, 1'b1);
      @(negedge clk);
      checkOutput("t4_err_count", 64'(bus.err_count), 64'd1);
      applyStimulus(64'h7FAA_0000_0000_0000, 2, 0, 2);
      checkResult("t4_after", 48'h0000_0000_AA7F, 32'h0, 1'b0);
      applyStimulus(64'h0102_0304_0506_0708, 3, 1, 2);
      checkResult("t4_bad_imm", 48'h0, 32'h0, 1'b1);
      @(negedge clk);
      checkOutput("t4_err_count2", 64'(bus.err_count), 64'd2);

      @(posedge clk);
      #1;
      bus.out_ready     = 1'b0;
      accepted          = 0;
      delivered         = 0;
      bus.in_imm_bytes  = 4'd2;
      bus.in_disp_bytes = 4'd1;
      bus.in_op_size    = 2'd1;
      bus.in_field      = streamWord(0);
      bus.in_valid      = 1'b1;
      repeat (6) begin
         @(negedge clk);
         if (bus.in_ready) accepted++;
         @(posedge clk);
         #1;
         bus.in_field = streamWord(accepted);
      end
      @(negedge clk);
      checkOutput("t5_accepts_stalled", 64'(accepted), 64'(DEPTH));
      checkOutput("t5_in_ready_full", 64'(bus.in_ready), 64'd0);
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      for (int n = 0; n < 30; n++) begin
         @(negedge clk);
         if (bus.out_valid && bus.out_ready) delivered++;
         if (bus.in_valid && bus.in_ready) accepted++;
         @(posedge clk);
         #1;
         if (accepted < 6) bus.in_field = streamWord(accepted);
         else bus.in_valid = 1'b0;
      end
      checkOutput("t5_accepted", 64'(accepted), 64'd6);
      checkOutput("t5_delivered", 64'(delivered), 64'd6);

      bus.out_ready = 1'b0;
      applyStimulus(64'h1111_2222_3333_4444, 4, 4, 2);
      applyStimulus(64'h5555_6666_7777_8888, 2, 1, 1);
      repeat (2) @(posedge clk);
      #1;
      bus.flush         = 1'b1;
      bus.in_valid      = 1'b1;
      bus.in_field      = 64'h0;
      bus.in_imm_bytes  = 4'd6;
      bus.in_disp_bytes = 4'd4;
      @(negedge clk);
      checkOutput("t6_in_ready_flush", 64'(bus.in_ready), 64'd0);
      @(posedge clk);
      #1;
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      @(negedge clk);
      checkOutput("t6_out_valid", 64'(bus.out_valid), 64'd0);
      checkOutput("t6_err_count", 64'(bus.err_count), 64'd2);
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("t6_nothing_left", 64'(bus.out_valid), 64'd0);
      checkOutput("t6_err_count_after", 64'(bus.err_count), 64'd2);

      for (int n = 0; n < 3000; n++) begin
         @(posedge clk);
         #1;
         reset         = ($urandom_range(0, 799) == 0);
         bus.flush     = ($urandom_range(0, 49) == 0);
         bus.in_valid  = ($urandom_range(0, 3) != 0);
         bus.out_ready = ($urandom_range(0, 2) != 0);
         bus.in_field  = {$urandom, $urandom};
         ib = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : immTable[$urandom_range(0, 4)];
         db = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : dispTable[$urandom_range(0, 2)];
         bus.in_imm_bytes  = 4'(ib);
         bus.in_disp_bytes = 4'(db);
         bus.in_op_size    = 2'($urandom_range(0, 3));
      end
      @(posedge clk);
      #1;
      reset         = 1'b0;
      bus.flush     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      repeat (10) @(posedge clk);
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end
endmodule
